// File: rtl/booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl
// Sequencing controller for a radix-2 Booth multiplier datapath.
// One multiplication runs LOAD, then WIDTH pairs of EVAL/SHIFT, then DONE.
// In each EVAL the pair {Q[0],Q[-1]} selects add (01), subtract (10) or
// nothing (00/11). The internal step counter is cleared on load and advanced
// on every shift. Its step strobe (en_pp) is the shift strobe itself.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   i_start_valid   request to start; operands already presented
//   o_start_ready   controller idle, start can be accepted
//   i_abort         synchronous cancel of an in-flight operation
//   i_q_lsb         datapath multiplier bit Q[0]
//   i_q_m1          datapath extra bit Q[-1]
//   o_load          strobe: load operands, clear A and Q[-1]
//   o_add           strobe: A <= A + M (EVAL only)
//   o_sub           strobe: A <= A - M (EVAL only)
//   o_shift         strobe: arithmetic right shift of {A,Q,Q[-1]}
//   o_en_pp         step strobe to partial-product counter (== o_shift)
//   o_step_cnt      completed iterations
//   o_busy          high in every state except IDLE
//   o_done_valid    product in datapath is final
//   i_done_ready    consumer accepts the product
// -----------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic             i_abort,
    input  logic             i_q_lsb,
    input  logic             i_q_m1,
    output logic             o_load,
    output logic             o_add,
    output logic             o_sub,
    output logic             o_shift,
    output logic             o_en_pp,
    output logic [CNT_W-1:0] o_step_cnt,
    output logic             o_busy,
    output logic             o_done_valid,
    input  logic             i_done_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start_ready;
    logic             r_load;
    logic             r_shift;
    logic             r_busy;
    logic             r_done_valid;
    logic [CNT_W-1:0] r_step_cnt;
    logic             w_abort;

    // Abort only has meaning while an operation is in flight.
    assign w_abort = i_abort && (r_state != S_IDLE);

    always_comb begin
        // NOTE: default assignment first keeps this purely combinational (no
        // latch) and also steers any illegal encoding back to IDLE.
        w_state_nxt = S_IDLE;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = (i_start_valid && r_start_ready) ? S_LOAD : S_IDLE;
                S_LOAD:  w_state_nxt = S_EVAL;
                S_EVAL:  w_state_nxt = S_SHIFT;
                S_SHIFT: w_state_nxt = (r_step_cnt == LAST_STEP) ? S_DONE : S_EVAL;
                S_DONE:  w_state_nxt = i_done_ready ? S_IDLE : S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore strobes are registered from the next state so they are glitch-free
    // and line up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state       <= S_IDLE;
            r_start_ready <= 1'b1;
            r_load        <= 1'b0;
            r_shift       <= 1'b0;
            r_busy        <= 1'b0;
            r_done_valid  <= 1'b0;
            r_step_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_ready <= (w_state_nxt == S_IDLE);
            r_load        <= (w_state_nxt == S_LOAD);
            r_shift       <= (w_state_nxt == S_SHIFT);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done_valid  <= (w_state_nxt == S_DONE);

            // Counter is cleared by abort or load, advanced by each shift and
            // saturates at WIDTH; after a normal finish it keeps WIDTH in IDLE.
            if (w_abort || r_state == S_LOAD) begin
                r_step_cnt <= '0;
            end else if (r_state == S_SHIFT && r_step_cnt != FULL_CNT) begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    // Booth decode: 01 -> add, 10 -> subtract; mutually exclusive by construction.
    assign o_add = (r_state == S_EVAL) && !i_q_lsb &&  i_q_m1;
    assign o_sub = (r_state == S_EVAL) &&  i_q_lsb && !i_q_m1;

    assign o_start_ready = r_start_ready;
    assign o_load        = r_load;
    assign o_shift       = r_shift;
    assign o_en_pp       = r_shift;
    assign o_busy        = r_busy;
    assign o_done_valid  = r_done_valid;
    assign o_step_cnt    = r_step_cnt;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_ctrl
// Directed self-checking bench for booth_seq_ctrl (WIDTH=8).
// Expected Booth decodes and final step counts are pushed to scoreboard
// queues when stimulus is driven and popped when the DUT reaches the
// corresponding EVAL / DONE cycle. Outputs are sampled 1 time unit after
// the rising edge; strobe pulses are tallied on the falling edge.
// -----------------------------------------------------------------------------
module tb_booth_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start_valid = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_q_lsb = 1'b0;
    logic          i_q_m1 = 1'b0;
    logic          i_done_ready = 1'b0;
    logic          o_start_ready;
    logic          o_load;
    logic          o_add;
    logic          o_sub;
    logic          o_shift;
    logic          o_en_pp;
    logic [CW-1:0] o_step_cnt;
    logic          o_busy;
    logic          o_done_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_shift = 0;
    int n_en_pp = 0;
    int n_load  = 0;
    int n_both  = 0;
    int n_diff  = 0;

    logic [1:0] sb_as[$];
    int         sb_cnt[$];

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start_valid (i_start_valid),
        .o_start_ready (o_start_ready),
        .i_abort       (i_abort),
        .i_q_lsb       (i_q_lsb),
        .i_q_m1        (i_q_m1),
        .o_load        (o_load),
        .o_add         (o_add),
        .o_sub         (o_sub),
        .o_shift       (o_shift),
        .o_en_pp       (o_en_pp),
        .o_step_cnt    (o_step_cnt),
        .o_busy        (o_busy),
        .o_done_valid  (o_done_valid),
        .i_done_ready  (i_done_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_shift) n_shift++;
        if (o_en_pp) n_en_pp++;
        if (o_load)  n_load++;
        if (o_add && o_sub) n_both++;
        if (o_shift !== o_en_pp) n_diff++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset / idle values: ready=1, busy=0, no strobes, given step count.
    task automatic idle_check(input string tag, input int exp_cnt);
        check({tag, " idle outs"},
              32'({o_start_ready, o_busy, o_load, o_add, o_sub, o_shift, o_en_pp, o_done_valid}),
              32'b1000_0000);
        check({tag, " idle cnt"}, 32'(o_step_cnt), 32'(exp_cnt));
    endtask

    // Full operation from IDLE: qbits holds the {q_lsb,q_m1} pair per
    // iteration, MSB pair first. bp_cycles = cycles of done_ready low.
    // abort_k >= 0 aborts in the SHIFT cycle where step_cnt == abort_k.
    task automatic run_op(input logic [15:0] qbits, input int bp_cycles,
                          input int abort_k, input string tag);
        int         t0;
        int         ns0;
        int         nl0;
        logic [1:0] q;
        logic [1:0] exp_as;
        check({tag, " start_ready"}, 32'(o_start_ready), 32'd1);
        t0  = cyc;
        ns0 = n_shift;
        sb_cnt.push_back(W);
        i_start_valid = 1'b1;
        step();
        i_start_valid = 1'b0;
        check({tag, " load"}, 32'({o_load, o_add, o_sub, o_shift, o_busy, o_done_valid}), 32'b10_0010);
        check({tag, " load time"}, 32'(cyc - t0), 32'd1);
        for (int k = 0; k < W; k++) begin
            q = qbits[15-2*k -: 2];
            i_q_lsb = q[1];
            i_q_m1  = q[0];
            sb_as.push_back({q == 2'b01, q == 2'b10});
            step();
            exp_as = sb_as.pop_front();
            check({tag, " eval"}, 32'({o_add, o_sub, o_shift, o_load, o_step_cnt}),
                  32'({exp_as, 2'b00, CW'(k)}));
            check({tag, " eval time"}, 32'(cyc - t0), 32'(2 + 2 * k));
            step();
            check({tag, " shift"}, 32'({o_shift, o_en_pp, o_add, o_sub, o_step_cnt}),
                  32'({4'b1100, CW'(k)}));
            if (k == abort_k) begin
                i_abort = 1'b1;
                step();
                i_abort = 1'b0;
                idle_check({tag, " after abort"}, 0);
                step();
                idle_check({tag, " abort+1"}, 0);
                void'(sb_cnt.pop_back());
                return;
            end
        end
        step();
        check({tag, " done outs"}, 32'({o_done_valid, o_busy, o_start_ready, o_shift}), 32'b1100);
        check({tag, " done cnt"}, 32'(o_step_cnt), 32'(sb_cnt.pop_front()));
        check({tag, " done time"}, 32'(cyc - t0), 32'(2 + 2 * W));
        check({tag, " shift pulses"}, 32'(n_shift - ns0), 32'(W));
        nl0 = n_load;
        for (int i = 0; i < bp_cycles; i++) begin
            i_start_valid = i[0];
            step();
            check({tag, " hold"}, 32'({o_done_valid, o_busy, o_start_ready, o_load, o_step_cnt}),
                  32'({4'b1100, CW'(W)}));
        end
        i_start_valid = 1'b0;
        i_done_ready  = 1'b1;
        step();
        i_done_ready  = 1'b0;
        idle_check({tag, " exit"}, W);
        check({tag, " no extra load"}, 32'(n_load - nl0), 32'd0);
    endtask

    // Start an operation with q bits 00 and stop in the first DONE cycle.
    task automatic go_to_done(input string tag);
        i_start_valid = 1'b1;
        step();
        i_start_valid = 1'b0;
        i_q_lsb = 1'b0;
        i_q_m1  = 1'b0;
        repeat (2 * W + 1) step();
        check({tag, " reached done"}, 32'({o_done_valid, o_step_cnt}), 32'({1'b1, CW'(W)}));
    endtask

    initial begin
        int loads[$];
        int dones[$];
        int nl0;

        // 1. Reset held for 3 cycles, then release.
        repeat (3) step();
        idle_check("reset", 0);
        reset = 1'b0;
        step();
        idle_check("post reset", 0);

        // 1. Timing with all-zero multiplier bits.
        run_op(16'h0000, 0, -1, "t1");

        // 2. Booth decode 10,11,01,00,10,01,00,11.
        run_op(16'b10_11_01_00_10_01_00_11, 0, -1, "t2");

        // 3. Backpressure for 5 cycles with start_valid pulsed meanwhile.
        run_op(16'h6C39, 5, -1, "t3");

        // 5. Abort during SHIFT at step_cnt=3, then a full operation.
        run_op(16'h5A5A, 0, 3, "t5 abort");
        run_op(16'h936C, 0, -1, "t5 full");

        // Abort in IDLE has no effect: start still accepted. Then abort in LOAD.
        i_start_valid = 1'b1;
        i_abort       = 1'b1;
        step();
        i_start_valid = 1'b0;
        check("abort idle load", 32'({o_load, o_busy, o_start_ready}), 32'b110);
        step();
        i_abort = 1'b0;
        idle_check("abort in load", 0);

        // Abort in DONE discards the result.
        go_to_done("abort done");
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        idle_check("abort in done", 0);
        step();
        idle_check("abort in done+1", 0);

        // 4. Back-to-back with start_valid and done_ready held high.
        i_start_valid = 1'b1;
        i_done_ready  = 1'b1;
        for (int i = 0; i < 42; i++) begin
            i_q_lsb = i[1];
            i_q_m1  = i[0];
            step();
            if (o_load)       loads.push_back(cyc);
            if (o_done_valid) dones.push_back(cyc);
        end
        i_start_valid = 1'b0;
        i_done_ready  = 1'b0;
        check("b2b load count", 32'(loads.size()), 32'd3);
        check("b2b done count", 32'(dones.size()), 32'd2);
        if (loads.size() >= 2 && dones.size() >= 1) begin
            check("b2b load spacing", 32'(loads[1] - loads[0]), 32'd19);
            check("b2b load after done", 32'(loads[1] - dones[0]), 32'd2);
            check("b2b op length", 32'(dones[0] - (loads[0] - 1)), 32'd18);
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        idle_check("b2b abort", 0);

        // 6a. Reset together with abort in mid-EVAL.
        i_start_valid = 1'b1;
        step();
        i_start_valid = 1'b0;
        i_q_lsb = 1'b0;
        i_q_m1  = 1'b1;
        step();
        check("t6 in eval", 32'({o_add, o_busy, o_shift}), 32'b110);
        reset   = 1'b1;
        i_abort = 1'b1;
        step();
        reset   = 1'b0;
        i_abort = 1'b0;
        idle_check("t6 reset eval", 0);

        // Exactly one start accepted after release.
        nl0 = n_load;
        i_start_valid = 1'b1;
        step();
        i_start_valid = 1'b0;
        i_done_ready  = 1'b1;
        repeat (25) step();
        i_done_ready  = 1'b0;
        check("t6 one start", 32'(n_load - nl0), 32'd1);
        idle_check("t6 after op", W);

        // 6b. Reset in DONE.
        go_to_done("t6 done");
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_check("t6 reset done", 0);

        // Global strobe invariants over the whole run.
        check("add&sub overlap", 32'(n_both), 32'd0);
        check("shift vs en_pp", 32'(n_diff), 32'd0);
        check("shift eq en_pp count", 32'(n_en_pp), 32'(n_shift));
        check("scoreboard empty", 32'(sb_as.size() + sb_cnt.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Control FSM for the radix-2 Booth multiplier datapath. Accepts a start handshake and issues the load strobe. For each of WIDTH iterations, it decodes the multiplier LSB pair into add, subtract or none, then issues an arithmetic-shift strobe. It presents a done handshake at the end. It contains its own step counter (cleared on load, advanced per shift), and its step strobe is the en_pp that drives the partial-product counter.

Parameters:
WIDTH, 8, operand width in bits = number of Booth iterations (>=2)
CNT_W, $clog2(WIDTH+1), step counter width; must hold the value WIDTH

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start_valid  input  1  request to begin a multiplication (operands already presented to datapath)
start_ready  output  1  controller idle and able to accept start
abort  input  1  synchronous cancel of an in-flight operation
q_lsb  input  1  datapath multiplier bit Q[0]
q_m1  input  1  datapath extra bit Q[-1]
load  output  1  one-cycle strobe: datapath loads operands, clears A and Q[-1]
add  output  1  one-cycle strobe: A <= A + M
sub  output  1  one-cycle strobe: A <= A - M
shift  output  1  one-cycle strobe: arithmetic right shift of {A,Q,Q[-1]}
en_pp  output  1  step strobe to partial-product counter; identical to shift
step_cnt  output  CNT_W  completed iterations
busy  output  1  high in every state except IDLE
done_valid  output  1  product in datapath is final
done_ready  input  1  consumer accepts the product

Behaviour:
- Reset values:
  - State IDLE.
  - start_ready=1.
  - load, add, sub, shift, en_pp, busy and done_valid are 0.
  - step_cnt=0.
- All strobes are Moore outputs decoded from state. The exception is add/sub: in EVAL these are decoded combinationally from q_lsb/q_m1.
- States and transitions:
  - IDLE: start_ready=1. On start_valid&start_ready, go to LOAD.
  - LOAD: load=1, step_cnt<=0. Go to EVAL.
  - EVAL: {q_lsb,q_m1}=01 -> add=1; 10 -> sub=1; 00 or 11 -> neither. add&sub is never 1. Go to SHIFT.
  - SHIFT: shift=en_pp=1, step_cnt<=step_cnt+1. If step_cnt==WIDTH-1, go to DONE; else go to EVAL.
  - DONE: done_valid=1, held until done_ready. On done_ready, go to IDLE. step_cnt holds WIDTH.
- Timing: start accepted at cycle T.
  - load at T+1.
  - EVAL at T+2+2k, SHIFT at T+3+2k, for k=0..WIDTH-1.
  - done_valid first high at T+2+2*WIDTH; with WIDTH=8 this is T+18.
- Back-to-back: at least one IDLE cycle separates done_ready acceptance and the next start acceptance.
- start_valid outside IDLE is ignored; no queuing.
- Abort, in any state other than IDLE, forces IDLE on the next edge:
  - step_cnt<=0.
  - No done_valid is produced.
  - No strobe is issued in the abort cycle's successor.
  - Abort in DONE discards the result.
  - Abort in IDLE has no effect.
- Priority: reset > abort > normal transitions. Reset mid-operation behaves identically to abort and restores the reset values.
- step_cnt never exceeds WIDTH and never wraps.
- Illegal state encodings recover to IDLE.

Test Plan:
1. Reset sequence (WIDTH=8): assert reset 3 cycles -> start_ready=1, busy=0, all strobes 0, step_cnt=0. Then start at T -> load only at T+1, first shift at T+3, done_valid at T+18, step_cnt=8.
2. Booth decode with q bits per iteration 10,11,01,00,10,01,00,11 -> sub/none/add/none/sub/add/none/none in consecutive EVAL cycles. Exactly 8 shift and 8 en_pp pulses. add and sub never high together.
3. Backpressure: done_ready low for 5 cycles after done_valid -> done_valid, busy and step_cnt=8 held. start_valid pulsed meanwhile -> ignored (start_ready=0). After done_ready=1 -> IDLE next cycle.
4. Back-to-back: start_valid held high continuously with done_ready=1 -> second load exactly 2 cycles after DONE-exit edge. Each op takes 19 cycles, start acceptance to DONE exit.
5. Abort at step_cnt=3 during SHIFT -> IDLE next cycle, step_cnt=0, busy=0, no done_valid. New start then runs a full 8 iterations.
6. reset asserted together with abort mid-EVAL, and separately reset in DONE -> reset values next cycle. Exactly one start is accepted after reset release.
